drop_timer: RTL and testbench
=============================

DROP_TIMER -- requirements
Module: drop_timer

Interface
REQ-001 Parameter TICK_DIV, default 100, SHALL be the number of clk cycles per time unit; legal range 2..65535.
REQ-002 Parameter HOLD_TICKS, default 4, SHALL be the number of time units drop_en is held in DROP; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle pulse meaning "baggage loaded, begin timing".
REQ-006 abort  input  1  SHALL be a level meaning "cancel the current operation".
REQ-007 drop_req  input  1  SHALL be a one-cycle pulse meaning "operator requests drop".
REQ-008 t_lim_in  input  16  SHALL be the time limit in time units, sampled only on start.
REQ-009 t_act  output  16  SHALL be elapsed time units since the last accepted start.
REQ-010 t_lim  output  16  SHALL be the t_lim_in value captured at the last accepted start.
REQ-011 drop_en  output  1  SHALL be the drop enable/verdict to the display_and_drop stage.
REQ-012 busy  output  1  SHALL be 1 while in ARMED or DROP.
REQ-013 drop_done  output  1  SHALL be a one-cycle pulse when DROP completes.

Function
REQ-014 The FSM SHALL have four states: IDLE, ARMED, DROP and EXPIRED.
REQ-015 The tick prescaler SHALL count 0..TICK_DIV-1 and SHALL be cleared on every entry to ARMED or DROP.
  - Tick = one-cycle strobe when the prescaler equals TICK_DIV-1.
REQ-016 IDLE:
  - t_act=0, drop_en=0.
  - start -> ARMED, capturing t_lim<=t_lim_in and t_act<=0.
REQ-017 ARMED:
  - drop_en=0.
  - t_act SHALL increment by 1 on each tick.
REQ-018 ARMED, tick with t_act==t_lim -> EXPIRED on the same edge.
  - t_act SHALL become t_lim+1 and SHALL then freeze.
REQ-019 ARMED, drop_req with t_act<=t_lim -> DROP; t_act SHALL freeze.
REQ-020 ARMED, drop_req coincident with the expiring tick: drop_req SHALL win (-> DROP, t_act unchanged).
REQ-021 t_act SHALL saturate at 16'hFFFF, never wrap.
  - If t_lim==16'hFFFF, ARMED SHALL persist indefinitely until drop_req, abort or start.
REQ-022 DROP:
  - drop_en=1; hold for HOLD_TICKS ticks.
  - On the final tick -> IDLE, with drop_done=1 for exactly that cycle.
REQ-023 EXPIRED:
  - drop_en=1 (downstream shows HOT); t_act and t_lim held.
  - drop_req SHALL be ignored.
REQ-024 start SHALL be accepted in IDLE, ARMED (restart with recapture) and EXPIRED; it SHALL be ignored in DROP.
REQ-025 abort SHALL force IDLE from any state on the next edge, clearing t_act, drop_en and the prescaler.
  - abort SHALL take priority over start and drop_req.
REQ-026 t_lim SHALL change only on an accepted start.
  - t_lim SHALL retain its value through IDLE, abort and DROP completion.
REQ-027 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-028 Invariants:
  - drop_en=1 with t_act<=t_lim SHALL occur only in DROP.
  - drop_en=0 with t_act>t_lim SHALL never occur.

Reset
REQ-029 rst=1 SHALL immediately force:
  - state=IDLE
  - t_act=0, t_lim=0, drop_en=0, busy=0, drop_done=0
  - prescaler=0
REQ-030 While rst=1 all inputs SHALL be ignored; rst asserted mid-ARMED or mid-DROP SHALL abandon the operation with no drop_done pulse.
REQ-031 After rst deasserts, the first accepted start SHALL produce t_act=1 exactly TICK_DIV cycles after the start edge.

Verification (TICK_DIV=4, HOLD_TICKS=2)
REQ-032 Bench SHALL cover: start, t_lim_in=3, no drop_req -> t_act 0,1,2,3 every 4 cycles.
  - Then t_act=4, drop_en=1, EXPIRED 16 cycles after start; held thereafter.
REQ-033 Bench SHALL cover: start, t_lim_in=10, drop_req when t_act=5 -> drop_en=1, t_act=5 frozen.
  - drop_done pulse 8 cycles later; then t_act=0, drop_en=0, busy=0.
REQ-034 Bench SHALL cover: t_lim_in=2, drop_req on the same cycle as the tick that would set t_act=3 -> DROP, t_act=2, drop_en=1.
REQ-035 Bench SHALL cover: t_lim_in=16'hFFFF, t_act forced near saturation -> t_act holds 16'hFFFF, state stays ARMED, drop_en=0.
REQ-036 Bench SHALL cover: rst pulsed asynchronously (between clk edges) mid-DROP -> all outputs 0 immediately, no drop_done.
  - A later start times correctly.
REQ-037 Bench SHALL cover: start while in DROP -> ignored; start while EXPIRED -> t_lim recaptured, t_act=0, drop_en=0.

Source files
------------

// File: rtl/drop_timer_if.sv
// Bundle for the drop timer: control inputs, time limit input and the timing/verdict outputs.
interface drop_timer_if;
  logic        start;
  logic        abort;
  logic        drop_req;
  logic [15:0] t_lim_in;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy;
  logic        drop_done;

  modport master (
    output start, abort, drop_req, t_lim_in,
    input  t_act, t_lim, drop_en, busy, drop_done
  );

  modport slave (
    input  start, abort, drop_req, t_lim_in,
    output t_act, t_lim, drop_en, busy, drop_done
  );
endinterface

// File: rtl/drop_timer.sv
// Drop timer: times a loaded item in prescaled time units, grants a held drop window
// on operator request or flags expiry once the captured time limit is exceeded.
module drop_timer #(
  parameter int unsigned TICK_DIV   = 100,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic         clk,
  input  logic         rst,
  drop_timer_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]    HOLD_MAX  = 8'(HOLD_TICKS - 1);
  localparam logic [15:0]   T_SAT     = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DROP    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [7:0]    hold_q, hold_n;
  logic [15:0]   t_act_q, t_act_n;
  logic [15:0]   t_lim_q, t_lim_n;
  logic          drop_en_q, busy_q, done_q, done_n;
  logic          tick;

  // Prescaler only runs in ARMED/DROP and is zero elsewhere, so this strobe is inert outside them.
  assign tick = (presc_q == PRESC_MAX);

  // Next-state and datapath update; abort overrides everything, then start, then drop_req.
  always_comb begin
    state_n = state_q;
    presc_n = '0;
    hold_n  = hold_q;
    t_act_n = t_act_q;
    t_lim_n = t_lim_q;
    done_n  = 1'b0;

    if (bus.abort) begin
      state_n = IDLE;
      t_act_n = '0;
      hold_n  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          t_act_n = '0;
          if (bus.start) begin
            state_n = ARMED;
            t_lim_n = bus.t_lim_in;
          end
        end
        ARMED: begin
          presc_n = tick ? '0 : presc_q + 1'b1;
          if (bus.start) begin
            t_lim_n = bus.t_lim_in;
            t_act_n = '0;
            presc_n = '0;
          end else if (bus.drop_req) begin
            state_n = DROP;
            presc_n = '0;
            hold_n  = '0;
          end else if (tick) begin
            // A limit of all-ones can never be exceeded: keep counting into saturation instead.
            if ((t_act_q == t_lim_q) && (t_lim_q != T_SAT)) begin
              state_n = EXPIRED;
              t_act_n = t_lim_q + 16'd1;
              presc_n = '0;
            end else if (t_act_q != T_SAT) begin
              t_act_n = t_act_q + 16'd1;
            end
          end
        end
        DROP: begin
          presc_n = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (hold_q == HOLD_MAX) begin
              state_n = IDLE;
              done_n  = 1'b1;
              t_act_n = '0;
              hold_n  = '0;
              presc_n = '0;
            end else begin
              hold_n = hold_q + 8'd1;
            end
          end
        end
        EXPIRED: begin
          if (bus.start) begin
            state_n = ARMED;
            t_lim_n = bus.t_lim_in;
            t_act_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          t_act_n = '0;
        end
      endcase
    end
  end

  // State and output registers; flag outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      hold_q    <= '0;
      t_act_q   <= '0;
      t_lim_q   <= '0;
      drop_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      presc_q   <= presc_n;
      hold_q    <= hold_n;
      t_act_q   <= t_act_n;
      t_lim_q   <= t_lim_n;
      drop_en_q <= (state_n == DROP) || (state_n == EXPIRED);
      busy_q    <= (state_n == ARMED) || (state_n == DROP);
      done_q    <= done_n;
    end
  end

  assign bus.t_act     = t_act_q;
  assign bus.t_lim     = t_lim_q;
  assign bus.drop_en   = drop_en_q;
  assign bus.busy      = busy_q;
  assign bus.drop_done = done_q;

endmodule

// File: tb/tb_drop_timer.sv
// Directed bench for drop_timer with TICK_DIV=4, HOLD_TICKS=2; inputs change and outputs are checked on negedges.
module tb_drop_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  drop_timer_if bus ();

  drop_timer #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] lim);
    bus.t_lim_in = lim;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic pulse_drop();
    bus.drop_req = 1'b1;
    @(negedge clk);
    bus.drop_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".t_act"},     32'(bus.t_act),     32'd0);
    chk({tag, ".t_lim"},     32'(bus.t_lim),     32'd0);
    chk({tag, ".drop_en"},   32'(bus.drop_en),   32'd0);
    chk({tag, ".busy"},      32'(bus.busy),      32'd0);
    chk({tag, ".drop_done"}, 32'(bus.drop_done), 32'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.drop_req = 1'b0;
    bus.t_lim_in = '0;

    // Reset state
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Expiry: limit 3, t_act advances every 4 cycles, expires 16 cycles after start
    pulse_start(16'd3);
    chk("exp.t_lim", 32'(bus.t_lim), 32'd3);
    chk("exp.t_act0", 32'(bus.t_act), 32'd0);
    chk("exp.busy0", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("exp.t_act[%0d]", k), 32'(bus.t_act), 32'(k / 4));
      chk($sformatf("exp.drop_en[%0d]", k), 32'(bus.drop_en), 32'(k == 16));
      chk($sformatf("exp.busy[%0d]", k), 32'(bus.busy), 32'(k < 16));
    end
    bus.drop_req = 1'b1;  // ignored while expired
    repeat (8) @(negedge clk);
    bus.drop_req = 1'b0;
    chk("exp.hold_t_act", 32'(bus.t_act), 32'd4);
    chk("exp.hold_drop_en", 32'(bus.drop_en), 32'd1);
    chk("exp.hold_t_lim", 32'(bus.t_lim), 32'd3);

    // Restart from EXPIRED with limit 10, drop at t_act=5, DROP ignores start
    pulse_start(16'd10);
    chk("rst_exp.t_lim", 32'(bus.t_lim), 32'd10);
    chk("rst_exp.t_act", 32'(bus.t_act), 32'd0);
    chk("rst_exp.drop_en", 32'(bus.drop_en), 32'd0);
    chk("rst_exp.busy", 32'(bus.busy), 32'd1);
    repeat (20) @(negedge clk);
    chk("drop.t_act_before", 32'(bus.t_act), 32'd5);
    pulse_drop();
    chk("drop.t_act", 32'(bus.t_act), 32'd5);
    chk("drop.drop_en", 32'(bus.drop_en), 32'd1);
    chk("drop.busy", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    pulse_start(16'd7);
    chk("drop.start_ign_t_lim", 32'(bus.t_lim), 32'd10);
    chk("drop.start_ign_t_act", 32'(bus.t_act), 32'd5);
    chk("drop.start_ign_drop_en", 32'(bus.drop_en), 32'd1);
    repeat (3) @(negedge clk);
    chk("drop.done_early", 32'(bus.drop_done), 32'd0);
    @(negedge clk);
    chk("drop.done", 32'(bus.drop_done), 32'd1);
    chk("drop.end_t_act", 32'(bus.t_act), 32'd0);
    chk("drop.end_drop_en", 32'(bus.drop_en), 32'd0);
    chk("drop.end_busy", 32'(bus.busy), 32'd0);
    chk("drop.end_t_lim", 32'(bus.t_lim), 32'd10);
    @(negedge clk);
    chk("drop.done_pulse", 32'(bus.drop_done), 32'd0);

    // Drop request coincident with expiring tick: drop wins
    pulse_start(16'd2);
    repeat (11) @(negedge clk);
    chk("coinc.t_act_before", 32'(bus.t_act), 32'd2);
    pulse_drop();
    chk("coinc.t_act", 32'(bus.t_act), 32'd2);
    chk("coinc.drop_en", 32'(bus.drop_en), 32'd1);
    chk("coinc.busy", 32'(bus.busy), 32'd1);

    // Abort beats start and drop_req; t_lim retained
    bus.abort    = 1'b1;
    bus.drop_req = 1'b1;
    pulse_start(16'd9);
    bus.abort    = 1'b0;
    bus.drop_req = 1'b0;
    chk("abort.t_act", 32'(bus.t_act), 32'd0);
    chk("abort.drop_en", 32'(bus.drop_en), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.t_lim", 32'(bus.t_lim), 32'd2);

    // Saturation with limit 16'hFFFF
    pulse_start(16'hFFFF);
    @(negedge clk);
    force dut.t_act_q = 16'hFFFD;
    #1;
    release dut.t_act_q;
    @(negedge clk);
    chk("sat.forced", 32'(bus.t_act), 32'hFFFD);
    repeat (12) @(negedge clk);
    chk("sat.t_act", 32'(bus.t_act), 32'hFFFF);
    chk("sat.busy", 32'(bus.busy), 32'd1);
    chk("sat.drop_en", 32'(bus.drop_en), 32'd0);
    repeat (8) @(negedge clk);
    chk("sat.t_act_hold", 32'(bus.t_act), 32'hFFFF);
    chk("sat.busy_hold", 32'(bus.busy), 32'd1);
    chk("sat.drop_en_hold", 32'(bus.drop_en), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    // Asynchronous reset mid-DROP, then a fresh start times correctly
    pulse_start(16'd5);
    repeat (5) @(negedge clk);
    chk("arst.t_act_before", 32'(bus.t_act), 32'd1);
    pulse_drop();
    chk("arst.in_drop", 32'(bus.drop_en), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("arst.no_done[%0d]", k), 32'(bus.drop_done), 32'd0);
    end
    pulse_start(16'd1);
    chk("arst2.t_lim", 32'(bus.t_lim), 32'd1);
    repeat (3) @(negedge clk);
    chk("arst2.t_act3", 32'(bus.t_act), 32'd0);
    @(negedge clk);
    chk("arst2.t_act4", 32'(bus.t_act), 32'd1);
    repeat (3) @(negedge clk);
    chk("arst2.drop_en7", 32'(bus.drop_en), 32'd0);
    @(negedge clk);
    chk("arst2.t_act8", 32'(bus.t_act), 32'd2);
    chk("arst2.drop_en8", 32'(bus.drop_en), 32'd1);
    chk("arst2.busy8", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
